// File: rtl/manchester_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : manchester_rx_pkg
//  Description : Shared types and constants for the Manchester receive
//                deframer: FSM state encoding, line-symbol codes and the
//                bit-counter width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package manchester_rx_pkg;

    // Receiver FSM states, explicitly 2 bits wide.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        START_H2 = 2'd1,
        H1       = 2'd2,
        H2       = 2'd3
    } state_t;

    // Default code-word width and the matching bit-counter width.
    localparam int WORD_W_DEF = 32;
    localparam int CNT_W      = $clog2(WORD_W_DEF + 1);

    // Half-sample pairs {first, second} that form a legal symbol.
    localparam logic [1:0] SYM_ONE  = 2'b10;
    localparam logic [1:0] SYM_ZERO = 2'b01;

    // Counter width able to hold the value w (0..w inclusive).
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage : manchester_rx_pkg
`default_nettype wire

// File: rtl/manchester_rx_deframer_sipo.sv
`default_nettype none
// ============================================================================
//  Module      : rx_sipo
//  Description : WORD_W-bit serial-in shift register for decoded data bits.
//                o_next is the register value after the pending shift, so
//                the caller can capture a completed word in the same cycle
//                the final bit arrives.
//  Ports       : clk, rst      - clock, async active-high reset
//                i_shift       - shift i_bit in this cycle
//                i_clear       - clear the register (wins over i_shift)
//                i_bit         - decoded data bit
//                o_next        - value the register takes at this edge
//  Revision    : 1.0 - initial release
// ============================================================================
module rx_sipo
    import manchester_rx_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int LSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_shift,
    input  logic              i_clear,
    input  logic              i_bit,
    output logic [WORD_W-1:0] o_next
);

    logic [WORD_W-1:0] r_shreg;
    logic [WORD_W-1:0] w_shifted;

    // LSB-first: new bits enter at the top and walk down, so the first bit
    // received ends up in bit 0 after WORD_W shifts.
    generate
        if (LSB_FIRST != 0) begin : g_lsb_first
            assign w_shifted = {i_bit, r_shreg[WORD_W-1:1]};
        end else begin : g_msb_first
            assign w_shifted = {r_shreg[WORD_W-2:0], i_bit};
        end
    endgenerate

    assign o_next = i_clear ? '0 : (i_shift ? w_shifted : r_shreg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shreg <= '0;
        end else begin
            r_shreg <= o_next;
        end
    end

endmodule : rx_sipo
`default_nettype wire

// File: rtl/manchester_rx_deframer.sv
`default_nettype none
// ============================================================================
//  Module      : manchester_rx_deframer
//  Description : Manchester line receiver at two samples per bit. Locks onto
//                a start bit (rising edge from an idle-low line), decodes
//                WORD_W data bits and presents each word with a one-cycle
//                valid strobe; any illegal half-sample pair aborts the frame
//                with a one-cycle err strobe.
//  Ports       : clk    - system clock, one half-bit sample per edge
//                rst    - async active-high reset
//                din    - Manchester line, synchronous to clk
//                data_o - last successfully decoded word
//                valid  - one-cycle pulse, data_o updated this cycle
//                err    - one-cycle pulse, invalid symbol / frame aborted
//                busy   - frame in progress (state other than IDLE)
//  Revision    : 1.0 - initial release
// ============================================================================
module manchester_rx_deframer
    import manchester_rx_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int LSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din,
    output logic [WORD_W-1:0] data_o,
    output logic              valid,
    output logic              err,
    output logic              busy
);

    localparam int                 c_cnt_w    = cnt_width(WORD_W);
    localparam logic [c_cnt_w-1:0] c_last_idx = c_cnt_w'(WORD_W - 1);
    localparam logic [c_cnt_w-1:0] c_one      = c_cnt_w'(1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_prev;
    logic                 r_first;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic [1:0]           w_pair;
    logic                 w_shift;
    logic                 w_clear;
    logic                 w_load;
    logic                 w_err;
    logic [WORD_W-1:0]    w_word_nxt;

    assign w_pair = {r_first, din};

    rx_sipo #(
        .WORD_W    (WORD_W),
        .LSB_FIRST (LSB_FIRST)
    ) u_sipo (
        .clk     (clk),
        .rst     (rst),
        .i_shift (w_shift),
        .i_clear (w_clear),
        .i_bit   (r_first),
        .o_next  (w_word_nxt)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift     = 1'b0;
        w_clear     = 1'b0;
        w_load      = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            IDLE: begin
                // r_prev tracks the line in every state, so a frame ending
                // on a high half-sample hides an immediately following
                // start edge.
                if (!r_prev && din) begin
                    w_state_nxt = START_H2;
                end
            end
            START_H2: begin
                if (din) begin
                    w_err       = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = H1;
                end
            end
            H1: begin
                w_state_nxt = H2;
            end
            H2: begin
                if (w_pair == SYM_ONE || w_pair == SYM_ZERO) begin
                    // Decoded bit equals the first half-sample.
                    w_shift = 1'b1;
                    if (r_cnt == c_last_idx) begin
                        w_load      = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = IDLE;
                    end else begin
                        w_cnt_nxt   = r_cnt + c_one;
                        w_state_nxt = H1;
                    end
                end else begin
                    w_err       = 1'b1;
                    w_clear     = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_prev  <= 1'b0;
            r_first <= 1'b0;
            r_cnt   <= '0;
            data_o  <= '0;
            valid   <= 1'b0;
            err     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_prev  <= din;
            r_cnt   <= w_cnt_nxt;
            valid   <= w_load;
            err     <= w_err;
            if (r_state == H1) begin
                r_first <= din;
            end
            if (w_load) begin
                data_o <= w_word_nxt;
            end
        end
    end

    assign busy = (r_state != IDLE);

endmodule : manchester_rx_deframer
`default_nettype wire

// File: tb/tb_manchester_rx_deframer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_manchester_rx_deframer
//  Description : Scoreboard bench for manchester_rx_deframer (WORD_W=32,
//                LSB_FIRST=1). Stimulus pushes expected valid/err events
//                (kind, word, cycle) into a queue; a monitor on the falling
//                edge pops and compares whenever valid or err is seen.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_manchester_rx_deframer;

    localparam int c_word_w = 32;

    typedef struct {
        bit          is_err;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic                clk;
    logic                rst;
    logic                din;
    logic [c_word_w-1:0] data_o;
    logic                valid;
    logic                err;
    logic                busy;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t q[$];
    exp_t r_e;

    manchester_rx_deframer #(
        .WORD_W    (c_word_w),
        .LSB_FIRST (1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .din    (din),
        .data_o (data_o),
        .valid  (valid),
        .err    (err),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every valid/err pulse must match the next queued event.
    always @(negedge clk) begin
        if (valid || err) begin
            chk("busy_low_on_pulse", {63'd0, busy}, 64'd0);
            chk("valid_err_exclusive", {63'd0, valid && err}, 64'd0);
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: got valid=%0b err=%0b expected no pulse (cycle %0d)",
                         valid, err, cyc);
            end else begin
                r_e = q.pop_front();
                chk("pulse_is_err", {63'd0, err}, {63'd0, r_e.is_err});
                chk("pulse_cycle", 64'(cyc), 64'(r_e.cyc));
                if (!r_e.is_err) begin
                    chk("data_o", {32'd0, data_o}, {32'd0, r_e.data});
                end
            end
        end
    end

    task automatic half(input bit b);
        @(negedge clk);
        din = b;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) half(1'b0);
    endtask

    // Start bit plus the first nbits data bits of w (LSB first). t0 is the
    // clock edge that samples the start-bit rising edge.
    task automatic frame(input logic [31:0] w, input int nbits, input bit push, output int t0);
        exp_t e;
        @(negedge clk);
        din = 1'b1;
        t0  = cyc + 1;
        if (push) begin
            e.is_err = 1'b0;
            e.data   = w;
            e.cyc    = t0 + 2 * c_word_w + 1;
            q.push_back(e);
        end
        half(1'b0);
        for (int i = 0; i < nbits; i++) begin
            half(w[i]);
            half(!w[i]);
        end
    endtask

    task automatic push_err(input int at);
        exp_t e;
        e.is_err = 1'b1;
        e.data   = '0;
        e.cyc    = at;
        q.push_back(e);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 300 && q.size() != 0; i++) @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL %s: got %0d pending events expected 0", name, q.size());
            q.delete();
        end
    endtask

    initial begin
        int t0;
        rst = 1'b1;
        din = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(20);
        chk("reset_valid", {63'd0, valid}, 64'd0);
        chk("reset_err", {63'd0, err}, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_data", {32'd0, data_o}, 64'd0);

        // Single clean frame.
        frame(32'hA5A5_0F0F, c_word_w, 1'b1, t0);
        idle(4);
        drain("drain_single");

        // Two frames, one idle-low cycle between them.
        frame(32'h0000_0001, c_word_w, 1'b1, t0);
        idle(1);
        frame(32'hFFFF_FFFE, c_word_w, 1'b1, t0);
        idle(4);
        drain("drain_back_to_back");

        // Bit 7 forced to "1,1": err on its second half, data_o held.
        frame(32'h5555_AAAA, 7, 1'b0, t0);
        push_err(t0 + 17);
        half(1'b1);
        half(1'b1);
        idle(4);
        drain("drain_bad_symbol");
        chk("data_held_after_err", {32'd0, data_o}, {32'd0, 32'hFFFF_FFFE});
        frame(32'h1234_5678, c_word_w, 1'b1, t0);
        idle(4);
        drain("drain_after_err");

        // Start bit whose second half is high.
        @(negedge clk);
        din = 1'b1;
        t0  = cyc + 1;
        push_err(t0 + 1);
        half(1'b1);
        idle(4);
        drain("drain_start_err");
        chk("idle_after_start_err", {63'd0, busy}, 64'd0);

        // Reset in the middle of data bit 20, then a clean frame.
        frame(32'hDEAD_BEEF, 20, 1'b0, t0);
        @(negedge clk);
        chk("busy_mid_frame", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_data", {32'd0, data_o}, 64'd0);
        chk("async_rst_busy", {63'd0, busy}, 64'd0);
        chk("async_rst_valid", {63'd0, valid}, 64'd0);
        din = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(2);
        frame(32'hDEAD_BEEF, c_word_w, 1'b1, t0);
        idle(4);
        drain("drain_after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_manchester_rx_deframer
`default_nettype wire
